alu_share_ctrl: RTL

//  Round-robin controller that shares one 8-bit-result ALU core between two requesters.
//  - Each requester presents an opcode and two 4-bit operands (A, B).
//  - The block grants one request at a time, latches its operands and executes the op.
//  - It returns the registered result, tagged with the requester id, over a valid/ready response port.
//  - It sits between the switch/key front end and the display/LED result path.

---
 rtl/alu_share_ctrl_pkg.sv | 21 ++
 rtl/alu_share_ctrl_if.sv | 30 +++
 rtl/alu_share_ctrl_alu_core.sv | 44 ++++
 rtl/alu_share_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared opcode values and FSM state encoding for the two-requester ALU share controller.
package alu_share_pkg;

  localparam logic [2:0] OP_CAT    = 3'd0;
  localparam logic [2:0] OP_LOGIC  = 3'd1;
  localparam logic [2:0] OP_ADD_RC = 3'd2;
  localparam logic [2:0] OP_ADD    = 3'd3;
  localparam logic [2:0] OP_INC    = 3'd4;
  localparam logic [2:0] OP_NZ     = 3'd5;
  localparam logic [2:0] OP_ZERO6  = 3'd6;
  localparam logic [2:0] OP_ZERO7  = 3'd7;

  // The unused code 2'd3 is kept named so the FSM can steer it back to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/grant and valid/ready response bundle between the two requesters and the controller.
interface alu_share_ctrl_if #(
  parameter int W = 4
) ();

  logic [1:0]     req;
  logic [2:0]     op0;
  logic [2:0]     op1;
  logic [W-1:0]   a0;
  logic [W-1:0]   a1;
  logic [W-1:0]   b0;
  logic [W-1:0]   b1;
  logic [1:0]     gnt;
  logic           busy;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [2*W-1:0] rsp_data;

  modport master (
    output req, op0, op1, a0, a1, b0, b1, rsp_ready,
    input  gnt, busy, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, op0, op1, a0, a1, b0, b1, rsp_ready,
    output gnt, busy, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_share_ctrl_alu_core.sv
// Combinational ALU: op, a, b -> 2W-bit result; op 2 goes through an explicit ripple-carry adder.
module alu_core
  import alu_share_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]     i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_result
);

  logic [W:0]   w_carry;
  logic [W-1:0] w_sum;
  logic [W:0]   w_add;
  logic [W:0]   w_inc;

  assign w_carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_fa
      assign w_sum[gi]     = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
      assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_inc = {1'b0, i_a} + {{W{1'b0}}, 1'b1};

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_CAT:    o_result = {i_a, i_b};
      OP_LOGIC:  o_result = {i_a | i_b, i_a ^ i_b};
      OP_ADD_RC: o_result = {{(W-1){1'b0}}, w_carry[W], w_sum};
      OP_ADD:    o_result = {{(W-1){1'b0}}, w_add};
      OP_INC:    o_result = {{(W-1){1'b0}}, w_inc};
      OP_NZ:     o_result = {{(2*W-1){1'b0}}, (|i_a) || (|i_b)};
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter, operand latch and response register wrapped around one shared alu_core.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int W       = 4,
  parameter bit RR_INIT = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_reset_b,
  alu_share_ctrl_if.slave bus
);

  state_t         r_state;
  state_t         w_state_next;
  logic           r_ptr;
  logic           r_id;
  logic [2:0]     r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [1:0]     r_gnt;
  logic           r_rsp_id;
  logic [2*W-1:0] r_rsp_data;

  logic           w_accept;
  logic           w_win;
  logic           w_rsp_load;
  logic           w_release;
  logic [2*W-1:0] w_alu_result;

  alu_core #(.W(W)) u_alu_core (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu_result)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_b) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  // A lone request wins outright; the pointer only breaks a tie.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_win        = r_ptr;
    w_rsp_load   = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          w_accept     = 1'b1;
          w_win        = (bus.req == 2'b11) ? r_ptr : bus.req[1];
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        w_rsp_load   = 1'b1;
        w_state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_b) begin
      r_ptr      <= RR_INIT;
      r_id       <= 1'b0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_gnt      <= 2'b00;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_gnt <= w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;
      if (w_accept) begin
        r_id <= w_win;
        r_op <= w_win ? bus.op1 : bus.op0;
        r_a  <= w_win ? bus.a1  : bus.a0;
        r_b  <= w_win ? bus.b1  : bus.b0;
      end
      if (w_rsp_load) begin
        r_rsp_data <= w_alu_result;
        r_rsp_id   <= r_id;
      end
      if (w_release) r_ptr <= ~r_rsp_id;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;

endmodule
